decryption_r2: RTL and testbench

- Receiver-side counterpart of the R2 encryption stage.
- Recomputes the shared key k = exp mod p from the received public exponent value.
- Recovers the plaintext as r2 = c1 XOR k.
- Uses a bit-serial restoring remainder engine (one exponent bit per clock), so no combinational 64/32 divider is needed. The block sits after the receiver's exponentiation stage and feeds the recovered r2 to the key-confirmation logic.

---
 rtl/decryption_r2_if.sv | 29 ++
 rtl/decryption_r2.sv | 121 ++++++++++++
 tb/tb_decryption_r2.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/decryption_r2_if.sv
// Request/result bundle for decryption_r2: operands in, busy/done/err and the
// recovered key and plaintext out, plus the FSM state for observation.
interface decryption_r2_if #(
   parameter int EXP_W = 64,
   parameter int P_W   = 32
);
   // start is a one-shot request: it is taken only while busy is low and the
   // block is idle; there is no back-pressure, the requester watches busy/done.
   logic             start;
   logic [EXP_W-1:0] c1;
   logic [P_W-1:0]   p;
   logic [EXP_W-1:0] exp;
   logic             busy;
   logic             done;
   logic             err;
   logic [EXP_W-1:0] k_o;
   logic [EXP_W-1:0] r2_o;
   logic [1:0]       fsm_state;

   modport master (
      output start, c1, p, exp,
      input  busy, done, err, k_o, r2_o, fsm_state
   );

   modport slave (
      input  start, c1, p, exp,
      output busy, done, err, k_o, r2_o, fsm_state
   );
endinterface

// File: rtl/decryption_r2.sv
// Receiver R2 stage: k = exp mod p by bit-serial restoring remainder, r2 = c1 ^ k.
// Optional macro DECRYPT_FAST_PATH_EN: exp < p skips the serial reduction.
module decryption_r2 #(
   parameter int EXP_W = 64,
   parameter int P_W   = 32
) (
   input logic               clk,
   input logic               rst,
   decryption_r2_if.slave    bus
);
   localparam int CNT_W = $clog2(EXP_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state;
   logic [EXP_W-1:0] c1_q;
   logic [P_W-1:0]   p_q;
   logic [EXP_W-1:0] exp_q;
   logic [P_W:0]     rem;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             done;
   logic             err;
   logic [EXP_W-1:0] k_o;
   logic [EXP_W-1:0] r2_o;

   logic [P_W:0]     t;
   logic [P_W:0]     rem_next;
   logic             fast_ok;

   // One restoring step: shift in the next exponent bit, subtract p if it fits.
   always_comb begin
      t        = {rem[P_W-1:0], exp_q[cnt]};
      rem_next = t;
      if (t >= {1'b0, p_q}) begin
         rem_next = t - {1'b0, p_q};
      end
   end

`ifdef DECRYPT_FAST_PATH_EN
   assign fast_ok = (bus.exp < {{(EXP_W-P_W){1'b0}}, bus.p});
`else
   assign fast_ok = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         c1_q  <= '0;
         p_q   <= '0;
         exp_q <= '0;
         rem   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         k_o   <= '0;
         r2_o  <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  c1_q  <= bus.c1;
                  p_q   <= bus.p;
                  exp_q <= bus.exp;
                  cnt   <= CNT_W'(EXP_W - 1);
                  busy  <= 1'b1;
                  if (bus.p == '0) begin
                     rem   <= '0;
                     state <= FIN;
                  end else if (fast_ok) begin
                     rem   <= {1'b0, bus.exp[P_W-1:0]};
                     state <= FIN;
                  end else begin
                     rem   <= '0;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= rem_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  state <= FIN;
               end
            end
            FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
               if (p_q == '0) begin
                  err  <= 1'b1;
                  k_o  <= '0;
                  r2_o <= '0;
               end else begin
                  // rem[P_W] is always zero here, so this is a plain zero-extension.
                  k_o  <= EXP_W'(rem);
                  r2_o <= c1_q ^ EXP_W'(rem);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.err       = err;
   assign bus.k_o       = k_o;
   assign bus.r2_o      = r2_o;
   assign bus.fsm_state = state;
endmodule

// File: tb/tb_decryption_r2.sv
// Directed bench for decryption_r2: nominal, boundary, busy, held-start and reset cases.
module tb_decryption_r2;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   decryption_r2_if #(.EXP_W(64), .P_W(32)) bus ();

   decryption_r2 #(.EXP_W(64), .P_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef DECRYPT_FAST_PATH_EN
   localparam int SMALL_LAT = 1;
`else
   localparam int SMALL_LAT = 65;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Issues one request (accept edge E0) and watches the next 100 edges.
   task automatic run_req(input logic [63:0] c, input logic [31:0] pp, input logic [63:0] e,
                          input bit disturb, output int done_at, output int n_done,
                          output int busy_low, output bit err_seen);
      bus.c1 = c; bus.p = pp; bus.exp = e; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      done_at = -1; n_done = 0; busy_low = 0; err_seen = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         if (disturb && i == 10) begin
            bus.c1 = ~c; bus.p = 32'd3; bus.exp = 64'd77; bus.start = 1'b1;
         end
         if (disturb && i == 11) bus.start = 1'b0;
         tick();
         if (bus.done) begin
            n_done++;
            if (done_at < 0) done_at = i;
            err_seen = err_seen | bus.err;
         end else if (done_at < 0 && !bus.busy) begin
            busy_low++;
         end
      end
   endtask

   initial begin
      int done_at, n_done, busy_low, first_done, cnt_done;
      bit err_seen, busy_after;
      total = 0; bad = 0;
      rst = 1'b0;
      bus.start = 1'b0; bus.c1 = '0; bus.p = '0; bus.exp = '0;
      tick(); tick();
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_err",  64'(bus.err),  64'd0);
      chk("rst_k",    bus.k_o,       64'd0);
      chk("rst_r2",   bus.r2_o,      64'd0);
      chk("rst_state", 64'(bus.fsm_state), 64'd0);
      rst = 1'b1;
      tick();

      // Nominal: 1000 mod 7 = 6, 0xFF ^ 6 = 0xF9
      run_req(64'hFF, 32'd7, 64'd1000, 1'b0, done_at, n_done, busy_low, err_seen);
      chk("nom_k", bus.k_o, 64'd6);
      chk("nom_r2", bus.r2_o, 64'hF9);
      chk("nom_lat", 64'(done_at), 64'd65);
      chk("nom_ndone", 64'(n_done), 64'd1);
      chk("nom_busy_gap", 64'(busy_low), 64'd0);
      chk("nom_err", 64'(err_seen), 64'd0);
      chk("nom_busy_end", 64'(bus.busy), 64'd0);

      // Max operands: 2^64-1 = (2^32-1)(2^32+1), so remainder 0
      run_req(64'h123456789ABCDEF0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0,
              done_at, n_done, busy_low, err_seen);
      chk("max_k", bus.k_o, 64'd0);
      chk("max_r2", bus.r2_o, 64'h123456789ABCDEF0);
      chk("max_err", 64'(err_seen), 64'd0);
      chk("max_lat", 64'(done_at), 64'd65);

      // Small exp: 5 mod 13 = 5, 0x10 ^ 5 = 0x15
      run_req(64'h10, 32'd13, 64'd5, 1'b0, done_at, n_done, busy_low, err_seen);
      chk("small_k", bus.k_o, 64'd5);
      chk("small_r2", bus.r2_o, 64'h15);
      chk("small_lat", 64'(done_at), 64'(SMALL_LAT));

      // Zero modulus: err with done on E1, results cleared
      run_req(64'hAA, 32'd0, 64'd55, 1'b0, done_at, n_done, busy_low, err_seen);
      chk("zero_lat", 64'(done_at), 64'd1);
      chk("zero_err", 64'(err_seen), 64'd1);
      chk("zero_k", bus.k_o, 64'd0);
      chk("zero_r2", bus.r2_o, 64'd0);
      chk("zero_ndone", 64'(n_done), 64'd1);
      chk("zero_busy_end", 64'(bus.busy), 64'd0);

      // exp = 0 gives k = 0, r2 = c1
      run_req(64'hCAFE, 32'd9, 64'd0, 1'b0, done_at, n_done, busy_low, err_seen);
      chk("exp0_k", bus.k_o, 64'd0);
      chk("exp0_r2", bus.r2_o, 64'hCAFE);

      // Disturbance while busy: result from first request, one done only
      run_req(64'h3C, 32'd10, 64'd12345, 1'b1, done_at, n_done, busy_low, err_seen);
      chk("dist_k", bus.k_o, 64'd5);
      chk("dist_r2", bus.r2_o, 64'h39);
      chk("dist_ndone", 64'(n_done), 64'd1);
      chk("dist_lat", 64'(done_at), 64'd65);

      // Start held high: re-accepted on the edge after FIN
      bus.c1 = 64'h55; bus.p = 32'd7; bus.exp = 64'd1000; bus.start = 1'b1;
      tick();
      first_done = -1; busy_after = 1'b0;
      for (int i = 1; i <= 70; i++) begin
         tick();
         if (bus.done && first_done < 0) first_done = i;
         if (first_done > 0 && i == first_done + 1) busy_after = bus.busy;
      end
      bus.start = 1'b0;
      chk("held_lat", 64'(first_done), 64'd65);
      chk("held_reaccept", 64'(busy_after), 64'd1);
      cnt_done = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.done) cnt_done++;
      end
      chk("held_second_done", 64'(cnt_done), 64'd1);
      chk("held_k", bus.k_o, 64'd6);
      chk("held_r2", bus.r2_o, 64'h53);

      // Reset mid-operation at E30
      bus.c1 = 64'hFF; bus.p = 32'd7; bus.exp = 64'd1000; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (29) tick();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_busy", 64'(bus.busy), 64'd0);
      chk("mid_k", bus.k_o, 64'd0);
      chk("mid_r2", bus.r2_o, 64'd0);
      chk("mid_state", 64'(bus.fsm_state), 64'd0);
      tick(); tick();
      rst = 1'b1;
      cnt_done = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (bus.done) cnt_done++;
      end
      chk("mid_no_done", 64'(cnt_done), 64'd0);
      run_req(64'hFF, 32'd7, 64'd1000, 1'b0, done_at, n_done, busy_low, err_seen);
      chk("post_k", bus.k_o, 64'd6);
      chk("post_lat", 64'(done_at), 64'd65);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
